// File: rtl/lmc_sequencer_if.sv
// Bus between the LMC sequencer and its surroundings (program RAM, data RAM,
// accumulator datapath, status). The master side is the sequencer itself.
interface lmc_sequencer_if;
    logic       run;
    logic [7:0] instr;
    logic       acc_zero;
    logic [2:0] pc;
    logic [2:0] ram2_addr;
    logic       ram2_we;
    logic       mux_sel;
    logic       acc_load;
    logic [1:0] state;
    logic       halted;
    logic [7:0] retired;

    modport master (
        input  run,
        input  instr,
        input  acc_zero,
        output pc,
        output ram2_addr,
        output ram2_we,
        output mux_sel,
        output acc_load,
        output state,
        output halted,
        output retired
    );

    modport slave (
        output run,
        output instr,
        output acc_zero,
        input  pc,
        input  ram2_addr,
        input  ram2_we,
        input  mux_sel,
        input  acc_load,
        input  state,
        input  halted,
        input  retired
    );
endinterface

// File: rtl/lmc_sequencer.sv
// LMC instruction sequencer: IDLE/FETCH/EXEC/HALT control FSM that fetches an
// 8-bit instruction from program RAM, decodes it and drives the data RAM and
// accumulator strobes. Every instruction takes one FETCH and one EXEC clock.
// Optional feature: define LMC_SEQ_SINGLE_STEP_EN to add a 'step' input that
// executes exactly one instruction per rising edge of step.
module lmc_sequencer (
    input  logic            clk,
    input  logic            reset_count,
`ifdef LMC_SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    lmc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        OP_HLT  = 3'b000,
        OP_LDA  = 3'b001,
        OP_STA  = 3'b010,
        OP_INP  = 3'b011,
        OP_BRA  = 3'b100,
        OP_BRZ  = 3'b101,
        OP_NOP6 = 3'b110,
        OP_NOP7 = 3'b111
    } opcode_t;

    state_t     state_q, state_d;
    logic [2:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] retired_q, retired_d;
    opcode_t    opcode;
    logic [2:0] operand;
    logic       start_ok;   // IDLE may launch a fetch
    logic       cont_ok;    // a finished instruction may chain straight into the next fetch
    logic       ram2_we_c, acc_load_c, mux_sel_c;

    assign opcode  = opcode_t'(ir_q[7:5]);
    assign operand = ir_q[2:0];

    // ir[4:3] carry no meaning for any opcode; fold them away explicitly.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_q[4:3];

`ifdef LMC_SEQ_SINGLE_STEP_EN
    logic step_q;
    logic step_rise;

    // Delay step by one clock so a held-high step yields a single rise pulse.
    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) step_q <= 1'b0;
        else             step_q <= step;
    end

    assign step_rise = step & ~step_q;
    assign start_ok  = bus.run & step_rise;
    assign cont_ok   = 1'b0;
`else
    assign start_ok  = bus.run;
    assign cont_ok   = bus.run;
`endif

    // Sequencer state register; reset forces everything back to a clean IDLE.
    always_ff @(posedge clk or posedge reset_count) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values computed by the combinational block, independent of
        // statement order.
        if (reset_count) begin
            state_q   <= ST_IDLE;
            pc_q      <= 3'd0;
            ir_q      <= 8'd0;
            retired_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Next-state, next-pc, instruction latch and retire counter.
    always_comb begin
        // NOTE: every variable gets a hold value first, so paths that do not
        // assign it cannot infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                ir_d    = bus.instr;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                // Every EXEC exit retires one instruction; the count sticks at 255.
                if (retired_q != 8'hFF) retired_d = retired_q + 8'd1;

                case (opcode)
                    OP_HLT:  pc_d = pc_q;
                    OP_BRA:  pc_d = operand;
                    // acc_zero still reflects the accumulator before this instruction.
                    OP_BRZ:  pc_d = bus.acc_zero ? operand : pc_q + 3'd1;
                    default: pc_d = pc_q + 3'd1;
                endcase

                if (opcode == OP_HLT) state_d = ST_HALT;
                else if (cont_ok)     state_d = ST_FETCH;
                else                  state_d = ST_IDLE;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // Datapath strobes, live only while an instruction is in EXEC.
    always_comb begin
        ram2_we_c  = 1'b0;
        acc_load_c = 1'b0;
        mux_sel_c  = 1'b0;
        if (state_q == ST_EXEC) begin
            case (opcode)
                OP_LDA: begin
                    acc_load_c = 1'b1;
                    mux_sel_c  = 1'b1;
                end
                OP_STA:  ram2_we_c  = 1'b1;
                OP_INP:  acc_load_c = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.ram2_addr = operand;
    assign bus.ram2_we   = ram2_we_c;
    assign bus.acc_load  = acc_load_c;
    assign bus.mux_sel   = mux_sel_c;
    assign bus.state     = state_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_lmc_sequencer.sv
// Self-checking bench for lmc_sequencer. A small instruction-level model walks
// the program in tb memory and queues the expected EXEC-cycle observations
// (pc, data address, strobes); a negedge monitor pops and compares them.
// Build with LMC_SEQ_SINGLE_STEP_EN defined to exercise the single-step variant.
module tb_lmc_sequencer;

    typedef struct packed {
        logic [2:0] pc;
        logic [2:0] addr;
        logic       we;
        logic       load;
        logic       sel;
    } exp_t;

    logic       clk;
    logic       reset_count;
`ifdef LMC_SEQ_SINGLE_STEP_EN
    logic       step;
`endif
    logic [7:0] prog [8];
    exp_t       exp_q [$];
    exp_t       e;
    bit         mon_en;
    int         exec_seen;
    int         n_checks;
    int         n_fail;

    lmc_sequencer_if bus ();

    lmc_sequencer dut (
        .clk         (clk),
        .reset_count (reset_count),
`ifdef LMC_SEQ_SINGLE_STEP_EN
        .step        (step),
`endif
        .bus         (bus)
    );

    // Program RAM: combinational read at the sequencer's pc.
    assign bus.instr = prog[bus.pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Instruction-level reference: queue what each EXEC cycle should show.
    task automatic gen_trace(input int max_steps);
        logic [2:0] p;
        logic [2:0] op;
        exp_t       x;
        p = 3'd0;
        for (int n = 0; n < max_steps; n++) begin
            op     = prog[p][7:5];
            x      = '0;
            x.pc   = p;
            x.addr = prog[p][2:0];
            x.load = (op == 3'd1) || (op == 3'd3);
            x.sel  = (op == 3'd1);
            x.we   = (op == 3'd2);
            exp_q.push_back(x);
            if (op == 3'd0) break;
            if (op == 3'd4 || (op == 3'd5 && bus.acc_zero)) p = prog[p][2:0];
            else                                              p = p + 3'd1;
        end
    endtask

    // Monitor: compare every EXEC cycle against the queue; strobes must be idle elsewhere.
    always @(negedge clk) begin
        if (!reset_count) begin
            if (bus.state == 2'b10) begin
                exec_seen++;
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        check("extra_exec", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("exec_pc", int'(bus.pc), int'(e.pc));
                        check("exec_addr", int'(bus.ram2_addr), int'(e.addr));
                        check("exec_strobes", int'({bus.ram2_we, bus.acc_load, bus.mux_sel}),
                              int'({e.we, e.load, e.sel}));
                    end
                end
            end else if (mon_en) begin
                check("idle_strobes", int'({bus.ram2_we, bus.acc_load, bus.mux_sel}), 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        mon_en      = 1'b0;
        bus.run     = 1'b0;
        reset_count = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_count = 1'b0;
        exec_seen   = 0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 8; i++) prog[i] = 8'h00;
    endtask

    // Run from reset until HLT; one IDLE->FETCH edge plus two edges per instruction.
    task automatic run_to_halt(input string tag, input int n_instr, input int exp_pc);
        int cyc;
        do_reset();
        gen_trace(8);
        mon_en  = 1'b1;
        bus.run = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.halted) break;
        end
        check({tag, "_halted"}, int'(bus.halted), 1);
        check({tag, "_halt_edges"}, cyc, 1 + 2 * n_instr);
        check({tag, "_pc"}, int'(bus.pc), exp_pc);
        check({tag, "_retired"}, int'(bus.retired), n_instr);
        check({tag, "_state"}, int'(bus.state), 3);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_stay_halt"}, int'(bus.state), 3);
        check({tag, "_stay_pc"}, int'(bus.pc), exp_pc);
        @(negedge clk);
        check({tag, "_trace_left"}, exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

`ifndef LMC_SEQ_SINGLE_STEP_EN
    task automatic test_wrap();
        clear_prog();
        prog[0] = 8'h86;    // BRA 6
        prog[6] = 8'hC0;    // NOP
        prog[7] = 8'hC0;    // NOP -> pc wraps to 0
        do_reset();
        gen_trace(4);
        mon_en  = 1'b1;
        bus.run = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        mon_en = 1'b0;
        check("wrap_drain", exp_q.size(), 0);
        bus.run = 1'b0;
    endtask

    task automatic test_run_drop();
        clear_prog();
        prog[0] = 8'h62;    // INP (operand 2)
        prog[1] = 8'h41;    // STA 1, must not start
        do_reset();
        gen_trace(1);
        mon_en  = 1'b1;
        bus.run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.state == 2'b10) break;
        end
        check("drop_in_exec", int'(bus.state), 2);
        bus.run = 1'b0;
        @(posedge clk);
        #1;
        check("drop_state", int'(bus.state), 0);
        check("drop_pc", int'(bus.pc), 1);
        check("drop_retired", int'(bus.retired), 1);
        repeat (4) @(posedge clk);
        #1;
        check("drop_stay_idle", int'(bus.state), 0);
        check("drop_stay_retired", int'(bus.retired), 1);
        check("drop_trace_left", exp_q.size(), 0);
        mon_en = 1'b0;
    endtask

    task automatic test_reset_exec();
        bit found;
        clear_prog();
        prog[0] = 8'h21;
        prog[1] = 8'h43;
        do_reset();
        bus.run = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.ram2_we) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_sta_seen", int'(found), 1);
        reset_count = 1'b1;
        #1;
        check("rst_we_drop", int'(bus.ram2_we), 0);
        check("rst_state", int'(bus.state), 0);
        check("rst_pc", int'(bus.pc), 0);
        check("rst_retired", int'(bus.retired), 0);
        check("rst_load", int'({bus.acc_load, bus.mux_sel}), 0);
        @(negedge clk);
        reset_count = 1'b0;
        @(posedge clk);
        #1;
        check("rst_resume_fetch", int'(bus.state), 1);
        check("rst_resume_pc", int'(bus.pc), 0);
        bus.run = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_ret;
        clear_prog();
        prog[0] = 8'hC0;    // NOP
        prog[1] = 8'h80;    // BRA 0
        do_reset();
        bus.run = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exec_seen >= 600) break;
        end
        check("sat_exec_count", int'(exec_seen >= 600), 1);
        bus.run = 1'b0;
        repeat (4) @(negedge clk);
        exp_ret = (exec_seen > 255) ? 255 : exec_seen;
        check("sat_retired", int'(bus.retired), exp_ret);
        check("sat_idle", int'(bus.state), 0);
    endtask
`else
    task automatic test_step();
        for (int i = 0; i < 8; i++) prog[i] = 8'hC0;
        do_reset();
        gen_trace(3);
        mon_en  = 1'b1;
        bus.run = 1'b1;
        repeat (4) @(negedge clk);
        check("step_no_start", int'(bus.state), 0);
        check("step_no_retire", int'(bus.retired), 0);
        for (int k = 1; k <= 3; k++) begin
            step = 1'b1;
            repeat (8) @(negedge clk);
            check("step_idle", int'(bus.state), 0);
            check("step_retired", int'(bus.retired), k);
            check("step_pc", int'(bus.pc), k);
            step = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("step_trace_left", exp_q.size(), 0);
        mon_en = 1'b0;
    endtask
`endif

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exec_seen   = 0;
        mon_en      = 1'b0;
        reset_count = 1'b0;
        bus.run     = 1'b0;
        bus.acc_zero = 1'b0;
`ifdef LMC_SEQ_SINGLE_STEP_EN
        step        = 1'b0;
`endif
        clear_prog();

        // Asynchronous reset: outputs must clear before any clock edge.
        #3 reset_count = 1'b1;
        #1;
        check("reset_state", int'(bus.state), 0);
        check("reset_pc", int'(bus.pc), 0);
        check("reset_retired", int'(bus.retired), 0);
        check("reset_halted", int'(bus.halted), 0);
        check("reset_strobes", int'({bus.ram2_we, bus.acc_load, bus.mux_sel}), 0);
        repeat (2) @(negedge clk);
        reset_count = 1'b0;

`ifndef LMC_SEQ_SINGLE_STEP_EN
        // LDA 1, STA 3, HLT
        clear_prog();
        prog[0] = 8'h21;
        prog[1] = 8'h43;
        prog[2] = 8'h00;
        run_to_halt("basic", 3, 2);

        // BRZ 5 taken, then HLT at 5
        clear_prog();
        prog[0] = 8'hA5;
        bus.acc_zero = 1'b1;
        run_to_halt("brz_taken", 2, 5);

        // BRZ 5 not taken, falls through to HLT at 1
        bus.acc_zero = 1'b0;
        run_to_halt("brz_fall", 2, 1);

        test_wrap();
        test_run_drop();
        test_reset_exec();
        test_saturate();
`else
        test_step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
